data_memory_unit: RTL and testbench

Word-organised data memory for the monocycle RISC-V CPU. It sits directly upstream of the register-write-data selector and drives its memory-read input (`DataRd`). It performs little-endian byte, half and word stores on the clock edge, and combinational loads with sign or zero extension selected by `DMCtrl` (funct3). It also keeps a sticky misalignment error flag and a store counter for debug.

---
 rtl/data_memory_unit_if.sv | 22 ++
 rtl/data_memory_unit.sv | 105 ++++++++++
 tb/tb_data_memory_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_unit_if.sv
// Bus bundle between the CPU datapath and the data memory.
// master: CPU side (drives address, store data and control).
// slave : memory side (returns load data and debug status).
interface data_memory_unit_if;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic [31:0] DataRd;
  logic        MisalignErr;
  logic [31:0] WrCount;

  modport master (
    output Address, DataWr, DMWr, DMCtrl,
    input  DataRd, MisalignErr, WrCount
  );

  modport slave (
    input  Address, DataWr, DMWr, DMCtrl,
    output DataRd, MisalignErr, WrCount
  );
endinterface

// File: rtl/data_memory_unit.sv
// Word-organised data memory for the monocycle RISC-V core.
// Little-endian byte/half/word stores on the rising edge, combinational
// loads with sign/zero extension chosen by DMCtrl (funct3), a sticky
// misalignment flag and a committed-store counter.
// Optional build macro: DM_MISALIGN_TRAP_EN
//   defined   -> misaligned loads read 0, misaligned stores are dropped,
//                MisalignErr latches on any misaligned valid access.
//   undefined -> low address bits are forced aligned, MisalignErr stays 0.
module data_memory_unit #(
  parameter int DEPTH = 256
) (
  input logic                clk,
  input logic                rst,
  data_memory_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

`ifdef DM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [31:0]   cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          ctrl_valid, ctrl_store, is_half, is_word, misalign;
  logic          commit;
  logic [31:0]   word_rd, shifted, wmask, wdata;
  logic          unused_addr_hi;

  // Upper address bits wrap away; kept only to make that explicit.
  assign unused_addr_hi = ^bus.Address[31:AW+2];
  assign idx            = bus.Address[AW+1:2];

  // Decode access size, misalignment and the effective byte lane.
  always_comb begin
    ctrl_valid = 1'b0;
    ctrl_store = 1'b0;
    case (bus.DMCtrl)
      3'b000, 3'b001, 3'b010: begin ctrl_valid = 1'b1; ctrl_store = 1'b1; end
      3'b100, 3'b101:         ctrl_valid = 1'b1;
      default:                ;
    endcase
    is_half  = (bus.DMCtrl[1:0] == 2'b01);
    is_word  = (bus.DMCtrl == 3'b010);
    misalign = (is_half && bus.Address[0]) || (is_word && (bus.Address[1:0] != 2'b00));
    if (is_word)      lane = 2'b00;
    else if (is_half) lane = {bus.Address[1], 1'b0};
    else              lane = bus.Address[1:0];
  end

  // Combinational load path with extension; misaligned loads read 0 when trapping.
  always_comb begin
    word_rd    = mem_q[idx];
    shifted    = word_rd >> {lane, 3'b000};
    bus.DataRd = '0;
    if (!(TRAP && misalign)) begin
      case (bus.DMCtrl)
        3'b000:  bus.DataRd = {{24{shifted[7]}}, shifted[7:0]};
        3'b100:  bus.DataRd = {24'h0, shifted[7:0]};
        3'b001:  bus.DataRd = {{16{shifted[15]}}, shifted[15:0]};
        3'b101:  bus.DataRd = {16'h0, shifted[15:0]};
        3'b010:  bus.DataRd = word_rd;
        default: bus.DataRd = '0;
      endcase
    end
  end

  // Next-state for the array, store counter and sticky error flag.
  always_comb begin
    case (bus.DMCtrl[1:0])
      2'b00:   begin wmask = 32'h0000_00FF << {lane, 3'b000}; wdata = {4{bus.DataWr[7:0]}};  end
      2'b01:   begin wmask = 32'h0000_FFFF << {lane, 3'b000}; wdata = {2{bus.DataWr[15:0]}}; end
      default: begin wmask = 32'hFFFF_FFFF;                   wdata = bus.DataWr;           end
    endcase
    commit = bus.DMWr && ctrl_store && !(TRAP && misalign);
    mem_d  = mem_q;
    if (commit) mem_d[idx] = (mem_q[idx] & ~wmask) | (wdata & wmask);
    cnt_d  = commit ? cnt_q + 32'd1 : cnt_q;
    err_d  = err_q | (TRAP && ctrl_valid && misalign);
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.WrCount     = cnt_q;
  assign bus.MisalignErr = err_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: a byte-addressed reference model
// predicts each cycle's load data, store count and error flag; a separate
// monitor compares them against the DUT on the falling edge.
module tb_data_memory_unit;
  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;
`ifdef DM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  data_memory_unit_if bus ();

  data_memory_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] cnt;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  m_mem [NB];
  logic [31:0] m_cnt;
  logic        m_err;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic int size_of(logic [2:0] c);
    case (c)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_mis(logic [31:0] addr, logic [2:0] c);
    int unsigned a = addr % 4;
    int n = size_of(c);
    return (n > 1) && ((a % n) != 0);
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] addr, logic [2:0] c);
    int n = size_of(c);
    int unsigned a;
    logic [31:0] v = 0;
    if (n == 0) return 32'h0;
    if (TRAP && is_mis(addr, c)) return 32'h0;
    a = addr % NB;
    a = a - (a % n);
    for (int i = 0; i < n; i++) v = v | ({24'h0, m_mem[a + i]} << (8 * i));
    if (!c[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_edge(logic [31:0] addr, logic [31:0] data, logic wr, logic [2:0] c);
    int n = size_of(c);
    int unsigned a;
    bit mis = is_mis(addr, c);
    if (TRAP && n > 0 && mis) m_err = 1'b1;
    if (wr && c <= 3'd2 && !(TRAP && mis)) begin
      a = addr % NB;
      a = a - (a % n);
      for (int i = 0; i < n; i++) m_mem[a + i] = data[8 * i +: 8];
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) m_mem[i] = 8'h00;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // One bus cycle: drive, predict the pre-edge view, then apply the edge to the model.
  task automatic op(logic [31:0] addr, logic [31:0] data, logic wr, logic [2:0] c,
                    string tag, bit use_exp = 1'b0, logic [31:0] exp_rd = 32'h0);
    exp_t e;
    bus.Address = addr;
    bus.DataWr  = data;
    bus.DMWr    = wr;
    bus.DMCtrl  = c;
    e.rd  = use_exp ? exp_rd : model_load(addr, c);
    e.cnt = m_cnt;
    e.err = m_err;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) model_edge(addr, data, wr, c);
    #1;
  endtask

  // Store request cut short by an asynchronous reset inside the same cycle.
  task automatic rst_mid(logic [31:0] addr);
    exp_t e;
    bus.Address = addr;
    bus.DataWr  = 32'hA5A5_A5A5;
    bus.DMWr    = 1'b1;
    bus.DMCtrl  = 3'b010;
    #2;
    rst = 1'b1;
    model_clear();
    e.rd  = 32'h0;
    e.cnt = 32'h0;
    e.err = 1'b0;
    e.tag = "rst_mid";
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.DataRd !== e.rd) begin
          n_bad++;
          $display("FAIL %s DataRd got %08h want %08h", e.tag, bus.DataRd, e.rd);
        end
        n_vec++;
        if (bus.WrCount !== e.cnt) begin
          n_bad++;
          $display("FAIL %s WrCount got %0d want %0d", e.tag, bus.WrCount, e.cnt);
        end
        n_vec++;
        if (bus.MisalignErr !== e.err) begin
          n_bad++;
          $display("FAIL %s MisalignErr got %0b want %0b", e.tag, bus.MisalignErr, e.err);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    model_clear();
    bus.Address = 0;
    bus.DataWr  = 0;
    bus.DMWr    = 0;
    bus.DMCtrl  = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    op(32'h000, 0, 0, 3'b010, "rst_lw0",   1, 32'h0);
    op(32'h3FC, 0, 0, 3'b010, "rst_lw3fc", 1, 32'h0);

    op(32'h010, 32'h8899_AABB, 1, 3'b010, "sw10");
    op(32'h010, 0, 0, 3'b010, "lw10",  1, 32'h8899_AABB);
    op(32'h013, 0, 0, 3'b000, "lb13",  1, 32'hFFFF_FF88);
    op(32'h013, 0, 0, 3'b100, "lbu13", 1, 32'h0000_0088);
    op(32'h013, 0, 0, 3'b010, "lw13");

    op(32'h011, 32'h0000_007F, 1, 3'b000, "sb11");
    op(32'h010, 0, 0, 3'b010, "lw10_sb", 1, 32'h8899_7FBB);
    op(32'h012, 32'h0000_F00D, 1, 3'b001, "sh12");
    op(32'h010, 0, 0, 3'b010, "lw10_sh", 1, 32'hF00D_7FBB);
    op(32'h012, 0, 0, 3'b001, "lh12",  1, 32'hFFFF_F00D);
    op(32'h012, 0, 0, 3'b101, "lhu12", 1, 32'h0000_F00D);

    op(32'h400, 32'h1234_5678, 1, 3'b010, "sw400");
    op(32'h000, 0, 0, 3'b010, "lw0_wrap", 1, 32'h1234_5678);
    op(32'h000, 32'hFFFF_FFFF, 1, 3'b011, "st_undef");
    op(32'h000, 0, 0, 3'b010, "lw0_undef", 1, 32'h1234_5678);
    op(32'h000, 32'hFFFF_FFFF, 1, 3'b101, "st_lhu");
    op(32'h000, 0, 0, 3'b010, "lw0_lhu", 1, 32'h1234_5678);

    op(32'h021, 32'hDEAD_BEEF, 1, 3'b010, "sw21");
    op(32'h020, 0, 0, 3'b010, "lw20_mis", 1, TRAP ? 32'h0 : 32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) op(32'h020, 0, 0, 3'b010, "sticky");

    rst_mid(32'h010);
    op(32'h010, 0, 0, 3'b010, "post_rst_lw10", 1, 32'h0);
    op(32'h000, 0, 0, 3'b010, "post_rst_lw0",  1, 32'h0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) a = $urandom_range(0, 63);
      else                           a = $urandom_range(0, 2047);
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_F800);
      d = $urandom;
      op(a, d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rand");
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
